// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit and its fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_ADDR_W = 32;
  localparam int unsigned FQ_INST_W = 32;
  localparam int unsigned BYTE_W    = 8;

  typedef struct packed {
    logic [FQ_INST_W-1:0] inst;
    logic [FQ_ADDR_W-1:0] pc;
  } fq_entry_t;

  function automatic int unsigned byte_step(input int unsigned inst_w);
    return inst_w / BYTE_W;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch front-end bus: I-cache request/response, redirect input and decode handshake.
interface fetch_if #(
  parameter int unsigned ADDR = 32,
  parameter int unsigned INST = 32
);
  logic            ic_req;
  logic [ADDR-1:0] ic_addr;
  logic            ic_ready;
  logic            ic_valid;
  logic [INST-1:0] ic_inst;
  logic            br_valid;
  logic [ADDR-1:0] br_target;
  logic            dec_valid;
  logic [INST-1:0] dec_inst;
  logic [ADDR-1:0] dec_pc;
  logic            dec_ready;

  modport master (
    output ic_req, ic_addr, dec_valid, dec_inst, dec_pc,
    input  ic_ready, ic_valid, ic_inst, br_valid, br_target, dec_ready
  );

  modport slave (
    input  ic_req, ic_addr, dec_valid, dec_inst, dec_pc,
    output ic_ready, ic_valid, ic_inst, br_valid, br_target, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue of DEPTH entries with wrap-bit pointers and synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fq_entry_t,
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = CW - 1;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  T            mem_q [DEPTH];

  assign empty     = (wr_q == rd_q);
  assign count     = wr_q - rd_q;
  assign head_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop && !empty);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential I-cache requests, in-order response queue, redirects.
// Optional FETCH_BYPASS_EN: a response into an empty queue is presented to decode in the same cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     ADDR     = 32,
  parameter int unsigned     INST     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int unsigned     CW         = cnt_w(DEPTH);
  localparam int unsigned     STEP       = byte_step(INST);
  localparam int unsigned     ALIGN      = $clog2(STEP);
  localparam logic [ADDR-1:0] ALIGN_MASK = ~((ADDR'(1) << ALIGN) - ADDR'(1));

  typedef struct packed {
    logic [INST-1:0] inst;
    logic [ADDR-1:0] pc;
  } entry_t;

  logic [ADDR-1:0] pc_q, pc_d, rpc_q, rpc_d;
  logic [CW-1:0]   ocnt_q, ocnt_d, dcnt_q, dcnt_d, qcnt;
  logic [CW+1:0]   used;
  logic            req, acc, rsp, rsp_keep, bypass, push, pop, q_empty;
  entry_t          head, push_data;

  always_comb begin
    used     = (CW+2)'(qcnt) + (CW+2)'(ocnt_q) + (CW+2)'(dcnt_q);
    req      = !reset && !bus.br_valid && (used < (CW+2)'(DEPTH));
    acc      = req && bus.ic_ready;
    rsp      = bus.ic_valid && ((ocnt_q != '0) || (dcnt_q != '0));
    rsp_keep = rsp && !bus.br_valid && (dcnt_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass   = rsp_keep && q_empty && !reset;
`else
    bypass   = 1'b0;
`endif
    push      = rsp_keep && !(bypass && bus.dec_ready);
    pop       = !q_empty && bus.dec_ready && !bus.br_valid;
    push_data = '{inst: bus.ic_inst, pc: rpc_q};
  end

  // Drops owed after a redirect: everything outstanding, less whatever returns in that same cycle.
  always_comb begin
    pc_d   = acc ? pc_q + ADDR'(STEP) : pc_q;
    rpc_d  = rsp_keep ? rpc_q + ADDR'(STEP) : rpc_q;
    ocnt_d = ocnt_q + CW'(acc) - CW'(rsp_keep);
    dcnt_d = dcnt_q - CW'(rsp && (dcnt_q != '0));
    if (bus.br_valid) begin
      pc_d   = bus.br_target & ALIGN_MASK;
      rpc_d  = bus.br_target & ALIGN_MASK;
      ocnt_d = '0;
      dcnt_d = dcnt_q + ocnt_q - CW'(rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      ocnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      ocnt_q <= ocnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH),
    .T    (entry_t)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.br_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head_data(head),
    .empty    (q_empty),
    .count    (qcnt)
  );

  logic            dec_valid;
  logic [INST-1:0] dec_inst;
  logic [ADDR-1:0] dec_pc;

  always_comb begin
    dec_valid = !q_empty;
    dec_inst  = q_empty ? '0 : head.inst;
    dec_pc    = q_empty ? '0 : head.pc;
    if (bypass) begin
      dec_valid = 1'b1;
      dec_inst  = bus.ic_inst;
      dec_pc    = rpc_q;
    end
  end

  assign bus.ic_req    = req;
  assign bus.ic_addr   = pc_q;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_inst  = dec_inst;
  assign bus.dec_pc    = dec_pc;

  ic_valid_needs_request: assert property (
    @(posedge clk) disable iff (reset) !(bus.ic_valid && (ocnt_q == '0) && (dcnt_q == '0))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized I-cache/decode traffic against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.ADDR(32), .INST(32)) bus ();

  fetch_unit #(
    .ADDR    (32),
    .INST    (32),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    int unsigned due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        inflight[$];
  ent_t        expq[$];
  logic [31:0] m_pc;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_req = 0;
  int unsigned n_deliv = 0;
  logic [31:0] last_dpc;
  int unsigned p_ready, p_dec, p_rsp, lat_lo, lat_hi;
  bit          br_now = 0;
  logic [31:0] br_tgt;

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    bit          exp_req, exp_dv, byp, rsp;
    logic [31:0] exp_dpc, exp_dinst;
    req_t        r;
    ent_t        e;
    bus.ic_ready  = ($urandom_range(99) < p_ready);
    bus.dec_ready = ($urandom_range(99) < p_dec);
    bus.br_valid  = br_now;
    bus.br_target = br_tgt;
    rsp = (inflight.size() > 0) && (inflight[0].due <= cyc) && ($urandom_range(99) < p_rsp);
    bus.ic_valid = rsp;
    bus.ic_inst  = rsp ? inflight[0].inst : $urandom();
    #1;
    exp_req = !br_now && (expq.size() + inflight.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rsp && !br_now && (expq.size() == 0) && !inflight[0].stale;
`endif
    exp_dv = 1'b0;
    exp_dpc = '0;
    exp_dinst = '0;
    if (expq.size() > 0) begin
      exp_dv = 1'b1; exp_dpc = expq[0].pc; exp_dinst = expq[0].inst;
    end else if (byp) begin
      exp_dv = 1'b1; exp_dpc = inflight[0].addr; exp_dinst = inflight[0].inst;
    end

    checks++;
    if (bus.ic_req !== exp_req) begin
      errors++;
      $display("FAIL ic_req: got %b expected %b (cycle %0d)", bus.ic_req, exp_req, cyc);
    end
    if (exp_req) begin
      checks++;
      if (bus.ic_addr !== m_pc) begin
        errors++;
        $display("FAIL ic_addr: got %h expected %h (cycle %0d)", bus.ic_addr, m_pc, cyc);
      end
    end
    checks++;
    if (bus.dec_valid !== exp_dv) begin
      errors++;
      $display("FAIL dec_valid: got %b expected %b (cycle %0d)", bus.dec_valid, exp_dv, cyc);
    end
    if (exp_dv) begin
      checks++;
      if ({bus.dec_pc, bus.dec_inst} !== {exp_dpc, exp_dinst}) begin
        errors++;
        $display("FAIL dec_entry: got pc %h inst %h expected pc %h inst %h (cycle %0d)",
                 bus.dec_pc, bus.dec_inst, exp_dpc, exp_dinst, cyc);
      end
    end

    if (bus.ic_req && bus.ic_ready) n_req++;
    if (bus.dec_valid && bus.dec_ready && !br_now) begin
      n_deliv++;
      last_dpc = bus.dec_pc;
    end

    if (br_now) begin
      if (rsp) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      expq.delete();
      m_pc = br_tgt & ~32'h3;
    end else begin
      if (exp_dv && bus.dec_ready && !byp) void'(expq.pop_front());
      if (rsp) begin
        r = inflight.pop_front();
        if (!r.stale && !(byp && bus.dec_ready)) begin
          e.pc = r.addr; e.inst = r.inst;
          expq.push_back(e);
        end
      end
      if (exp_req && bus.ic_ready) begin
        r.addr = m_pc; r.inst = $urandom(); r.stale = 1'b0;
        r.due = cyc + $urandom_range(lat_hi, lat_lo);
        inflight.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    br_now = 1'b0;
  endtask

  // Holds reset for three cycles with a redirect pending; optionally lets in-flight responses land meanwhile.
  task automatic reset_dut(input bit late);
    reset = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_0200;
    bus.ic_ready  = 1'b1;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ic_valid = late && (inflight.size() > 0);
      bus.ic_inst  = $urandom();
      if (bus.ic_valid) begin
        bus.ic_inst = inflight[0].inst;
        void'(inflight.pop_front());
      end
      #1;
      checks++;
      if (bus.ic_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_ic_req: got %b expected 0", bus.ic_req);
      end
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if ({bus.ic_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc} !== {RESET_PC, 1'b0, 32'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_outputs: got addr %h dv %b inst %h pc %h expected addr %h dv 0 inst 0 pc 0",
                 bus.ic_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc, RESET_PC);
      end
    end
    reset = 1'b0;
    bus.br_valid = 1'b0;
    bus.ic_valid = 1'b0;
    inflight.delete();
    expq.delete();
    m_pc = RESET_PC;
    br_now = 1'b0;
    n_req = 0;
    n_deliv = 0;
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned dec, input int unsigned rs,
                           input int unsigned lo, input int unsigned hi);
    p_ready = rdy; p_dec = dec; p_rsp = rs; lat_lo = lo; lat_hi = hi;
  endtask

  task automatic test_reset();
    set_knobs(100, 100, 100, 1, 1);
    reset_dut(1'b0);
    step();
    checks++;
    if (n_req != 1) begin
      errors++;
      $display("FAIL first_request: got %0d requests expected 1", n_req);
    end
  endtask

  task automatic test_sequential();
    int unsigned d0;
    set_knobs(100, 100, 100, 1, 1);
    reset_dut(1'b0);
    repeat (12) step();
    d0 = n_deliv;
    repeat (10) step();
    checks++;
    if (n_deliv - d0 != 10) begin
      errors++;
      $display("FAIL steady_throughput: got %0d deliveries expected 10", n_deliv - d0);
    end
  endtask

  task automatic test_backpressure();
    set_knobs(100, 0, 100, 1, 1);
    reset_dut(1'b0);
    repeat (10) step();
    checks++;
    if (n_req != DEPTH) begin
      errors++;
      $display("FAIL credit_limit: got %0d requests expected %0d", n_req, DEPTH);
    end
    p_dec = 100;
    repeat (8) step();
    checks++;
    if (n_req <= DEPTH) begin
      errors++;
      $display("FAIL resume: got %0d requests expected more than %0d", n_req, DEPTH);
    end
  endtask

  task automatic wait_first_delivery(input logic [31:0] want, input string name);
    int unsigned d0;
    d0 = n_deliv;
    for (int i = 0; i < 20 && n_deliv == d0; i++) step();
    checks++;
    if (n_deliv == d0 || last_dpc !== want) begin
      errors++;
      $display("FAIL %s: got delivered=%0d pc %h expected pc %h", name, n_deliv - d0, last_dpc, want);
    end
  endtask

  task automatic test_redirect();
    set_knobs(100, 100, 100, 4, 4);
    reset_dut(1'b0);
    repeat (3) step();
    br_now = 1'b1;
    br_tgt = 32'h0000_0103;
    step();
    wait_first_delivery(32'h0000_0100, "redirect_target");
  endtask

  task automatic test_redirect_collision();
    set_knobs(100, 0, 100, 2, 2);
    reset_dut(1'b0);
    repeat (2) step();
    br_now = 1'b1;
    br_tgt = 32'h0000_0040;
    step();
    repeat (8) step();
    p_dec = 100;
    wait_first_delivery(32'h0000_0040, "collision_target");
  endtask

  task automatic test_push_pop_full();
    set_knobs(100, 0, 100, 1, 1);
    reset_dut(1'b0);
    repeat (6) step();
    for (int i = 0; i < 30; i++) begin
      p_dec = (i % 3 == 2) ? 0 : 100;
      step();
    end
  endtask

  task automatic test_random();
    set_knobs(70, 60, 70, 1, 6);
    reset_dut(1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0)
        set_knobs($urandom_range(100, 30), $urandom_range(100, 10), $urandom_range(100, 40),
                  1, $urandom_range(6, 1));
      if ($urandom_range(99) < 5) begin
        br_now = 1'b1;
        br_tgt = $urandom();
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    set_knobs(100, 100, 100, 3, 3);
    reset_dut(1'b0);
    repeat (2) step();
    reset_dut(1'b1);
    wait_first_delivery(RESET_PC, "post_reset_first_pc");
  endtask

  initial begin
    bus.ic_ready  = 1'b0;
    bus.ic_valid  = 1'b0;
    bus.ic_inst   = '0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;
    bus.dec_ready = 1'b0;
    br_tgt = '0;
    last_dpc = '0;
    m_pc = RESET_PC;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_push_pop_full();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit: generates sequential PCs, issues requests to the instruction cache over a valid/ready handshake, and buffers in-order responses in a configurable-depth fetch queue feeding decode. Supports multiple outstanding cache requests under credit control and front-end redirects that flush the queue and discard stale in-flight responses. Sits between the I-cache and the decode stage; it is the generalised successor of the single-request fetch stage.

## Interface
- ADDR, 32, address/PC width in bits
- INST, 32, instruction width in bits (multiple of 8)
- DEPTH, 4, fetch queue entries and maximum outstanding requests (power of two, ≥2)
- RESET_PC, 0, PC loaded at reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ic_req  out  1  request valid to I-cache
- ic_addr  out  ADDR  request address (current fetch PC)
- ic_ready  in  1  I-cache accepts request when ic_req && ic_ready
- ic_valid  in  1  response valid (in request order, latency ≥1 cycle)
- ic_inst  in  INST  response instruction
- br_valid  in  1  redirect request
- br_target  in  ADDR  redirect target
- dec_valid  out  1  queue head valid
- dec_inst  out  INST  head instruction
- dec_pc  out  ADDR  head PC
- dec_ready  in  1  decode consumes head when dec_valid && dec_ready

## Operation
- State: fetch PC `pc`, response PC `rpc`, queue occupancy `qcnt`, outstanding count `ocnt`, drop count `dcnt`.
- Credit rule: ic_req = !br_valid && (qcnt + ocnt + dcnt < DEPTH). Guarantees no queue overflow.
- Accepted request: pc <= pc + INST/8 (modulo 2^ADDR), ocnt += 1.
- Response with dcnt > 0: discarded, dcnt -= 1.
- Response with dcnt == 0: pushed with pc = rpc; rpc <= rpc + INST/8; ocnt -= 1.
- Pop on dec_valid && dec_ready.
- Redirect (br_valid): queue cleared; pc and rpc <= br_target with low log2(INST/8) bits zeroed; dcnt <= dcnt + ocnt − (1 if a response arrives this cycle and dcnt == 0, else 0) minus any dcnt decrement that cycle; ocnt <= 0. A response arriving in the redirect cycle is always discarded; a pop in that cycle is ignored.
- Simultaneous push and pop: qcnt unchanged; no bubble when queue has ≥1 entry.
- Responses with ic_valid while ocnt + dcnt == 0 are a protocol error; ignored (assertion in simulation).

## Timing
- Reset values: ic_req 0 during reset cycle, ic_addr = RESET_PC, dec_valid 0, dec_inst 0, dec_pc 0; pc = rpc = RESET_PC; qcnt = ocnt = dcnt = 0.
- First ic_req asserted cycle after reset deasserts, ic_addr = RESET_PC.
- Back-to-back requests: one per cycle while credits remain.
- Response to dec_valid: 1 cycle (registered queue) unless bypass enabled.
- After redirect, first request for br_target issues next cycle, subject to credits (drops in flight consume credits until they return).
- Redirect during reset: reset wins.

## Configuration
- FETCH_BYPASS_EN defined: when queue is empty and dcnt == 0, a valid response drives dec_valid/dec_inst/dec_pc combinationally in the same cycle; if dec_ready it is consumed without entering the queue, otherwise it is written to the queue.
- Undefined: every response is written to the queue; dec_valid earliest the following cycle.

## Structure
- Package fetch_pkg: fetch queue entry struct {inst, pc}, INST/8 byte-step constant, count-width helper (log2(DEPTH)+1).
- Sub-module fetch_queue: circular FIFO of DEPTH entries, head/tail pointers with wrap bit, push/pop/flush, count output. fetch_unit holds PC, credit and drop logic.

## Test plan
- Reset, ic_ready=1, 1-cycle response, dec_ready=1 -> ic_addr sequence 0x0,0x4,0x8,…; dec_pc matches, one instruction per cycle steady state.
- dec_ready=0 with DEPTH=4 -> exactly 4 requests issued, ic_req stays 0, dec_valid=1 with dec_pc=0x0 held; releasing dec_ready resumes requests.
- 3 outstanding at 4-cycle latency, br_valid with br_target=0x103 -> 3 stale responses dropped, dec_pc of next delivered instruction = 0x100, queue empty after redirect.
- Response arriving in the same cycle as br_valid -> not queued; dcnt counts only remaining in-flight responses.
- Push and pop same cycle at qcnt=DEPTH−1 -> qcnt unchanged, no overflow, order preserved.
- Reset asserted mid-stream with 2 outstanding -> all outputs return to reset values next cycle; late responses after reset are ignored and do not appear on decode.
